// File: rtl/instru_loader_if.sv
// Byte-stream input and instruction-memory write bundle for the boot loader.
// The master side feeds bytes and observes status; the slave side is the loader.
interface instru_loader_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             in_valid;
    logic [7:0]       in_byte;
    logic             in_ready;
    logic             im_we;
    logic [31:0]      im_addr;
    logic [31:0]      im_wdata;
    logic             busy;
    logic             done;
    logic             overflow;
    logic             cpu_stall;
    logic [CNT_W-1:0] word_count;

    modport master (
        output start, in_valid, in_byte,
        input  in_ready, im_we, im_addr, im_wdata,
        input  busy, done, overflow, cpu_stall, word_count
    );

    modport slave (
        input  start, in_valid, in_byte,
        output in_ready, im_we, im_addr, im_wdata,
        output busy, done, overflow, cpu_stall, word_count
    );
endinterface

// File: rtl/instru_loader.sv
// Boot-time instruction memory writer.
// Collects a big-endian byte stream into 32-bit words and writes them to
// consecutive word addresses, keeping the CPU stalled until a halt word has
// been written or the memory is full. All outputs come straight from flops.
module instru_loader #(
    parameter int SIZE_IM = 128,
    parameter int CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    instru_loader_if.slave bus
);

    localparam logic [31:0]      HALT_WORD = 32'hFC00_0000;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(SIZE_IM - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r;
    logic [1:0]       byte_cnt_r;
    logic [CNT_W-1:0] word_idx_r;
    logic [31:0]      asm_r;
    logic             in_ready_r;
    logic             im_we_r;
    logic [31:0]      im_addr_r;
    logic [31:0]      im_wdata_r;
    logic             busy_r;
    logic             done_r;
    logic             overflow_r;
    logic             cpu_stall_r;
    logic [CNT_W-1:0] word_count_r;

    logic             hs_s;
    logic [31:0]      asm_next_s;
    logic [31:0]      addr_s;

    // A byte moves only when the registered ready and the source's valid meet.
    assign hs_s       = in_ready_r & bus.in_valid;
    assign asm_next_s = {asm_r[23:0], bus.in_byte};
    assign addr_s     = 32'({word_idx_r, 2'b00});

    assign bus.in_ready   = in_ready_r;
    assign bus.im_we      = im_we_r;
    assign bus.im_addr    = im_addr_r;
    assign bus.im_wdata   = im_wdata_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.overflow   = overflow_r;
    assign bus.cpu_stall  = cpu_stall_r;
    assign bus.word_count = word_count_r;

    // Loader FSM: state, counters, assembly register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            byte_cnt_r   <= 2'd0;
            word_idx_r   <= '0;
            asm_r        <= 32'd0;
            in_ready_r   <= 1'b0;
            im_we_r      <= 1'b0;
            im_addr_r    <= 32'd0;
            im_wdata_r   <= 32'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            overflow_r   <= 1'b0;
            cpu_stall_r  <= 1'b1;
            word_count_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // A new load restarts from word 0 with a fresh byte phase.
                    if (bus.start) begin
                        state_r      <= ST_LOAD;
                        byte_cnt_r   <= 2'd0;
                        word_idx_r   <= '0;
                        word_count_r <= '0;
                        overflow_r   <= 1'b0;
                        done_r       <= 1'b0;
                        cpu_stall_r  <= 1'b1;
                        busy_r       <= 1'b1;
                        in_ready_r   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // start is deliberately ignored here; only bytes matter.
                    if (hs_s) begin
                        asm_r      <= asm_next_s;
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            state_r    <= ST_WRITE;
                            in_ready_r <= 1'b0;
                            im_we_r    <= 1'b1;
                            im_addr_r  <= addr_s;
                            im_wdata_r <= asm_next_s;
                        end
                    end
                end
                ST_WRITE: begin
                    im_we_r      <= 1'b0;
                    word_count_r <= word_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    word_idx_r   <= word_idx_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    // Halt wins over the capacity limit, so a halt in the last
                    // slot is a clean finish rather than an overflow.
                    if (asm_r == HALT_WORD) begin
                        state_r     <= ST_DONE;
                        overflow_r  <= 1'b0;
                        done_r      <= 1'b1;
                        cpu_stall_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else if (word_idx_r == LAST_IDX) begin
                        state_r     <= ST_DONE;
                        overflow_r  <= 1'b1;
                        done_r      <= 1'b1;
                        cpu_stall_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r    <= ST_LOAD;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b0;
                    im_we_r     <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    cpu_stall_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/instru_loader.md
Name: instru_loader

Overview:
- Boot-time writer for the instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Drives the instruction memory's write port (word-aligned byte addresses from 0) and holds the pipeline in stall until loading completes.
- Loading ends on the halt word 0xFC000000 or when memory is full.

Parameters:
- SIZE_IM, 128, instruction memory depth in 32-bit words; sets the capacity limit.
- CNT_W, 8, width of word_count; must satisfy 2^CNT_W > SIZE_IM.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load from IDLE or DONE.
- in_valid  input  1  byte stream valid.
- in_byte  input  8  stream data, most-significant byte of each word first.
- in_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  instruction memory write enable, one-cycle pulse per word.
- im_addr  output  32  byte address of the write, always a multiple of 4.
- im_wdata  output  32  instruction word to write.
- busy  output  1  high in LOAD or WRITE.
- done  output  1  high in DONE.
- overflow  output  1  memory filled without a halt word.
- cpu_stall  output  1  high in every state except DONE.
- word_count  output  CNT_W  number of words written in the current or last load.

Behaviour:
- States: IDLE, LOAD, WRITE, DONE. All state and outputs are registered.
- Reset (rst=1 at an edge), from any state including mid-word:
  - state=IDLE, in_ready=0, im_we=0, im_addr=0, im_wdata=0, busy=0, done=0, overflow=0, cpu_stall=1, word_count=0.
  - Byte counter=0, word index=0, assembly register=0; any partial word is discarded.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD. Clears byte counter, word index, word_count and overflow.
- LOAD:
  - in_ready=1.
  - Handshake is in_valid&in_ready: assembly register <= {assembly[23:0], in_byte}; byte counter increments mod 4.
  - Handshake on the 4th byte (counter==3) -> WRITE.
  - in_valid=0 -> hold all state; no timeout.
  - start is ignored.
- WRITE (exactly one cycle):
  - im_we=1, im_wdata = assembled word, im_addr = word_index<<2, in_ready=0.
  - Latency: im_we asserts the cycle after the 4th byte handshake.
  - At the end of the cycle, word_count and word_index increment.
  - Next state:
    - word==32'hFC000000 -> DONE; halt word is written; overflow=0.
    - else word_index==SIZE_IM-1 -> DONE, overflow=1.
    - else -> LOAD.
  - Halt at the last index takes priority: overflow=0.
- DONE:
  - done=1, cpu_stall=0, in_ready=0; further bytes are not accepted.
  - start=1 -> LOAD, clearing done, overflow, word_count, word index and byte counter. cpu_stall returns to 1 in the same cycle done drops.
- im_addr and im_wdata hold their last values when im_we=0.
- busy = (state==LOAD || state==WRITE).
- word_count saturation is not possible given the CNT_W constraint.

Test Plan:
1. Reset: assert rst for 2 cycles mid-stream -> in_ready=0, im_we=0, done=0, overflow=0, cpu_stall=1, word_count=0, im_addr=0.
2. Basic load: start, stream 20 08 00 05 FC 00 00 00 with in_valid held -> im_we pulses twice:
   - first with 0x20080005 @0x0, second with 0xFC000000 @0x4;
   - each pulse one cycle after the 4th byte; in_ready=0 during each pulse;
   - then done=1, cpu_stall=0, word_count=2, overflow=0.
3. Backpressure/gaps: same bytes with in_valid toggling every other cycle -> identical writes and addresses; no byte is dropped or duplicated; in_ready is low only in WRITE cycles and after DONE.
4. Capacity (SIZE_IM=4): send 4 non-halt words 0x00000001..0x00000004 -> writes @0x0, 0x4, 0x8, 0xC, then done=1, overflow=1, word_count=4. A 17th byte with in_valid=1 sees in_ready=0 and causes no write.
5. Reset mid-word: after bytes AB CD, assert rst, then start and send 11 22 33 44 FC 00 00 00 -> first write is 0x11223344 @0x0; no write contains AB or CD.
6. Restart/ignore: start pulsed during LOAD is ignored with no counter reset. start pulsed in DONE starts a new load:
   - done and overflow clear; cpu_stall=1;
   - the next word writes @0x0; word_count restarts at 1.
